// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, instruction memory and IF/ID pipeline register
//
// Ports:
//   clk          pipeline clock, all state updates on rising edge
//   rst          synchronous active-high reset
//   stall        hazard stall from ID; hold PC and IF/ID register
//   br_taken     branch resolved taken in EX
//   br_target    branch target byte address
//   jmp_valid    ID has decoded a j instruction
//   jmp_index    instr_index field of that j
//   pc           current fetch PC (byte address)
//   fd_pc        PC+4 of the instruction in fd_ir
//   fd_ir        fetched instruction to ID
//   fd_valid     fd_ir is a real (non-squashed) instruction
//   fetch_count  saturating count of valid instructions delivered to ID
//
// Optional feature macro: FETCH_DELAY_SLOT_EN
//   When defined, a jump redirect keeps the delay-slot fetch instead of squashing it.
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] NOP_WORD   = 32'h00000020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [25:0] jmp_index,
    output logic [31:0] pc,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_ir,
    output logic        fd_valid,
    output logic [31:0] fetch_count
);

    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    // Word-addressed instruction store, preloaded externally and never reset.
    logic [31:0] instruction [IMEM_DEPTH];

    logic [31:0]   pc_plus4;
    logic [31:0]   jmp_pc;
    logic [31:0]   br_pc;
    logic [31:0]   word;
    logic [31:0]   count_inc;
    logic [AW-1:0] word_idx;
    logic          in_range;

    assign pc_plus4  = pc + 32'd4;
    assign br_pc     = {br_target[31:2], 2'b00};
    assign jmp_pc    = {fd_pc[31:28], jmp_index, 2'b00};
    assign word_idx  = pc[AW+1:2];
    assign in_range  = ({2'b00, pc[31:2]} < 32'(IMEM_DEPTH));
    assign word      = in_range ? instruction[word_idx] : NOP_WORD;
    assign count_inc = (fetch_count == 32'hFFFF_FFFF) ? fetch_count : fetch_count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= 32'd0;
            fd_pc       <= 32'd0;
            fd_ir       <= NOP_WORD;
            fd_valid    <= 1'b0;
            fetch_count <= 32'd0;
        end else if (br_taken) begin
            // Branch is the older instruction: it wins over a same-cycle jump,
            // and the word fetched this cycle is on the wrong path.
            pc       <= br_pc;
            fd_pc    <= pc_plus4;
            fd_ir    <= NOP_WORD;
            fd_valid <= 1'b0;
        end else if (jmp_valid) begin
            pc    <= jmp_pc;
            fd_pc <= pc_plus4;
`ifdef FETCH_DELAY_SLOT_EN
            // The word behind the jump is its delay slot and must execute.
            fd_ir       <= word;
            fd_valid    <= 1'b1;
            fetch_count <= count_inc;
`else
            fd_ir    <= NOP_WORD;
            fd_valid <= 1'b0;
`endif
        end else if (!stall) begin
            pc          <= pc_plus4;
            fd_pc       <= pc_plus4;
            fd_ir       <= word;
            fd_valid    <= 1'b1;
            fetch_count <= count_inc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with behavioural model
module tb_instr_fetch_unit;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h00000020;
`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [25:0] jmp_index;
    logic [31:0] pc;
    logic [31:0] fd_pc;
    logic [31:0] fd_ir;
    logic        fd_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] mem [DEPTH];

    // Reference state
    logic [31:0] m_pc, m_fd_pc, m_fd_ir, m_count;
    logic        m_valid;

    instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_index  (jmp_index),
        .pc         (pc),
        .fd_pc      (fd_pc),
        .fd_ir      (fd_ir),
        .fd_valid   (fd_valid),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        if ((a >> 2) < DEPTH) return mem[a >> 2];
        return NOP;
    endfunction

    // Behavioural model: decide where the PC goes and what ID receives from the rules.
    always @(posedge clk) begin
        logic [31:0] n_pc, n_fd_pc, n_fd_ir, n_count;
        logic        n_valid, squash, deliver;
        if (rst) begin
            m_pc = 0; m_fd_pc = 0; m_fd_ir = NOP; m_valid = 0; m_count = 0;
        end else begin
            if (br_taken)       n_pc = br_target & 32'hFFFF_FFFC;
            else if (jmp_valid) n_pc = (m_fd_pc & 32'hF000_0000) | ({6'd0, jmp_index} << 2);
            else if (stall)     n_pc = m_pc;
            else                n_pc = m_pc + 4;
            squash  = br_taken || (jmp_valid && !DS);
            deliver = !squash && (jmp_valid || !stall);
            n_fd_pc = m_fd_pc; n_fd_ir = m_fd_ir; n_valid = m_valid; n_count = m_count;
            if (squash) begin
                n_fd_ir = NOP; n_valid = 0; n_fd_pc = m_pc + 4;
            end else if (deliver) begin
                n_fd_ir = fetch_word(m_pc); n_valid = 1; n_fd_pc = m_pc + 4;
                if (m_count != 32'hFFFF_FFFF) n_count = m_count + 1;
            end
            m_pc = n_pc; m_fd_pc = n_fd_pc; m_fd_ir = n_fd_ir; m_valid = n_valid; m_count = n_count;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("fd_pc", fd_pc, m_fd_pc);
            chk("fd_ir", fd_ir, m_fd_ir);
            chk("fd_valid", {31'd0, fd_valid}, {31'd0, m_valid});
            chk("fetch_count", fetch_count, m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; br_taken = 0; br_target = 0; jmp_valid = 0; jmp_index = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            dut.instruction[i] = mem[i];
        end

        // Reset state
        tick();
        chk("rst_pc", pc, 32'd0);
        chk("rst_fd_pc", fd_pc, 32'd0);
        chk("rst_fd_ir", fd_ir, NOP);
        chk("rst_valid", {31'd0, fd_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk_en = 1;
        rst = 0;

        // Free run of four fetches
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("run_fd_pc", fd_pc, 32'(4 * (i + 1)));
            chk("run_fd_ir", fd_ir, mem[i]);
            chk("run_valid", {31'd0, fd_valid}, 32'd1);
        end
        chk("run_count", fetch_count, 32'd4);
        chk("run_pc", pc, 32'd16);

        // Stall at pc=8
        rst = 1; tick(); rst = 0;
        tick(); tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'd8);
            chk("stall_fd_pc", fd_pc, 32'd8);
            chk("stall_fd_ir", fd_ir, mem[1]);
            chk("stall_count", fetch_count, 32'd2);
        end
        stall = 0;
        tick();
        chk("resume_fd_ir", fd_ir, mem[2]);
        chk("resume_fd_pc", fd_pc, 32'd12);

        // Jump from fd_pc=0x4C
        br_taken = 1; br_target = 32'h48; tick(); br_taken = 0;
        chk("br48_pc", pc, 32'h48);
        chk("br48_valid", {31'd0, fd_valid}, 32'd0);
        tick();
        chk("pre_j_fd_pc", fd_pc, 32'h4C);
        jmp_valid = 1; jmp_index = 26'd7; tick(); jmp_valid = 0;
        chk("j_pc", pc, 32'h1C);
        if (DS) begin
            chk("j_ds_valid", {31'd0, fd_valid}, 32'd1);
            chk("j_ds_ir", fd_ir, mem[19]);
        end else begin
            chk("j_sq_valid", {31'd0, fd_valid}, 32'd0);
            chk("j_sq_ir", fd_ir, NOP);
        end
        tick();
        chk("j_target_ir", fd_ir, mem[7]);
        chk("j_target_fd_pc", fd_pc, 32'h20);

        // Branch beats jump and stall
        br_taken = 1; br_target = 32'h58; jmp_valid = 1; jmp_index = 26'd3; stall = 1;
        tick();
        br_taken = 0; jmp_valid = 0; stall = 0;
        chk("bj_pc", pc, 32'h58);
        chk("bj_valid", {31'd0, fd_valid}, 32'd0);
        chk("bj_ir", fd_ir, NOP);
        tick();
        chk("bj_target_ir", fd_ir, mem[22]);

        // Out-of-range fetch at top of address space and wrap
        br_taken = 1; br_target = 32'hFFFF_FFFF; tick(); br_taken = 0;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_fd_ir", fd_ir, NOP);
        chk("wrap_fd_pc", fd_pc, 32'd0);
        chk("wrap_next_pc", pc, 32'd0);
        tick();
        chk("wrap_ir0", fd_ir, mem[0]);

        // Mid-run reset with fetch_count=10
        rst = 1; tick(); rst = 0;
        repeat (10) tick();
        chk("cnt10", fetch_count, 32'd10);
        rst = 1; tick(); rst = 0;
        chk("mid_rst_pc", pc, 32'd0);
        chk("mid_rst_valid", {31'd0, fd_valid}, 32'd0);
        chk("mid_rst_count", fetch_count, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom % 150) == 0;
            stall     = ($urandom % 5) == 0;
            br_taken  = ($urandom % 12) == 0;
            jmp_valid = ($urandom % 10) == 0;
            jmp_index = 26'($urandom % 80);
            if (($urandom % 8) == 0) br_target = 32'hFFFF_FF00 | 32'($urandom % 256);
            else                     br_target = 32'($urandom % 320);
            tick();
        end
        rst = 0; stall = 0; br_taken = 0; jmp_valid = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline. Holds the PC and the word-addressed instruction memory.
- Produces the IF/ID pipeline register (fd_pc, fd_ir, fd_valid) consumed directly by the ID stage.
- Applies stall, branch redirect (from EX) and jump redirect (from ID), with squash of wrong-path fetches.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit words in `instruction` memory.
- NOP_WORD, 32'h00000020, encoding injected on squash and out-of-range fetch (add r0,r0,r0).

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from ID; hold PC and IF/ID register.
- br_taken  in  1  branch resolved taken in EX.
- br_target  in  32  branch target byte address.
- jmp_valid  in  1  ID has decoded a `j` (opcode 000010).
- jmp_index  in  26  instr_index field of that `j`.
- pc  out  32  current fetch PC (byte address).
- fd_pc  out  32  PC+4 of the instruction in fd_ir.
- fd_ir  out  32  fetched instruction to ID.
- fd_valid  out  1  fd_ir is a real (non-squashed) instruction.
- fetch_count  out  32  count of valid instructions delivered to ID.

Behaviour:
- Reset (rst=1 at posedge): pc=0, fd_pc=0, fd_ir=NOP_WORD, fd_valid=0, fetch_count=0. `instruction` array is not reset; it is preloaded by the bench. Reset mid-run discards all in-flight state next edge.
- Fetch is combinational read: word = instruction[pc[log2(IMEM_DEPTH)+1:2]]. If pc[31:2] >= IMEM_DEPTH, the word is NOP_WORD.
- Next-PC priority (highest first):
  - rst: 0.
  - br_taken: {br_target[31:2],2'b00}.
  - jmp_valid: {fd_pc[31:28], jmp_index, 2'b00}.
  - stall: pc.
  - otherwise: pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Normal edge (no stall, no redirect): fd_ir<=word, fd_pc<=pc+4, fd_valid<=1, fetch_count++.
- Stall only: pc, fd_pc, fd_ir, fd_valid and fetch_count hold.
- Redirect (br_taken or jmp_valid) squashes the fetch in flight: fd_ir<=NOP_WORD, fd_valid<=0, fd_pc<=pc+4, fetch_count holds. Redirect overrides stall.
- br_taken and jmp_valid together: branch wins (older instruction). Jump is discarded; it is on the wrong path.
- Latency: redirect target instruction appears on fd_ir 2 edges after the redirect edge (1 bubble).
- fetch_count saturates at 32'hFFFFFFFF.

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- Defined: a jmp_valid redirect (without br_taken) does not squash. The instruction fetched that cycle (delay slot) loads normally with fd_valid=1 and fetch_count++. Branch redirects still squash.
- Undefined: behaviour exactly as above.

Test Plan:
- Reset then 4 free-run edges with instruction[0..3] preloaded -> fd_pc goes 4,8,12,16; fd_ir = instruction[0..3]; fetch_count=4; pc=16.
- stall=1 for 3 edges at pc=8 -> pc, fd_pc=8, fd_ir=instruction[1] and fetch_count all frozen; on release, fetch resumes at instruction[2].
- jmp_valid=1, jmp_index=7, fd_pc=0x4C -> next pc=0x1C. Without macro: fd_valid=0, fd_ir=NOP_WORD, then instruction[7] on the following edge. With FETCH_DELAY_SLOT_EN: delay-slot word delivered with fd_valid=1.
- br_taken=1, br_target=0x58, with simultaneous jmp_valid=1 and stall=1 -> pc=0x58, squash bubble, fd_ir=instruction[22] two edges later (or NOP_WORD if IMEM_DEPTH<=22).
- pc forced to 0xFFFFFFFC via br_target -> fd_ir=NOP_WORD (out of range), next pc=0 and instruction[0] is fetched.
- rst asserted mid-run with fetch_count=10 -> next edge pc=0, fd_valid=0, fetch_count=0.
